// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch and data requesters onto one SRAM-like bus port and
// routes in-order responses back through a 1-bit owner tag FIFO.
module mem_bus_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] tag_q, tag_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lock_valid_q, lock_valid_d;
  logic             lock_owner_q, lock_owner_d;
  logic [3:0]       starve_q, starve_d;

  logic grant_vld, grant_data, lock_hold, full, accept, pop, head;

  // Grant: sticky lock first, then starvation override, then data priority.
  always_comb begin
    grant_vld  = 1'b0;
    grant_data = 1'b0;
    lock_hold  = lock_valid_q && (lock_owner_q ? data_req : inst_req);
    if (lock_hold) begin
      grant_vld  = 1'b1;
      grant_data = lock_owner_q;
    end else if (inst_req && data_req && starve_q == 4'(STARVE_LIMIT)) begin
      grant_vld  = 1'b1;
      grant_data = 1'b0;
    end else if (data_req) begin
      grant_vld  = 1'b1;
      grant_data = 1'b1;
    end else if (inst_req) begin
      grant_vld  = 1'b1;
      grant_data = 1'b0;
    end
  end

  assign full      = (cnt_q == CW'(DEPTH));
  assign bus_req   = grant_vld && !full;
  assign bus_wr    = grant_vld && grant_data && data_wr;
  assign bus_size  = !grant_vld ? 2'd0  : (grant_data ? data_size  : 2'd2);
  assign bus_addr  = !grant_vld ? 32'd0 : (grant_data ? data_addr  : inst_addr);
  assign bus_wdata = !grant_vld ? 32'd0 : (grant_data ? data_wdata : 32'd0);

  assign accept       = bus_req && bus_addr_ok;
  assign inst_addr_ok = accept && !grant_data;
  assign data_addr_ok = accept && grant_data;

  // Responses with nothing outstanding are dropped without popping.
  assign pop          = bus_data_ok && (cnt_q != '0);
  assign head         = tag_q[rptr_q];
  assign inst_data_ok = pop && !head;
  assign data_data_ok = pop && head;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  always_comb begin
    tag_d  = tag_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (accept) begin
      tag_d[wptr_q] = grant_data;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // A stalled request pins the grant; a withdrawn one frees it the same cycle.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    if (lock_valid_q && !lock_hold) lock_valid_d = 1'b0;
    if (bus_req) begin
      lock_valid_d = !bus_addr_ok;
      lock_owner_d = grant_data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!inst_req || inst_addr_ok)
      starve_d = 4'd0;
    else if (data_addr_ok && starve_q < 4'(STARVE_LIMIT))
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tag_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      starve_q     <= 4'd0;
    end else begin
      tag_q        <= tag_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      starve_q     <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against a
// queue-based reference model of the arbiter.
module tb_mem_bus_arbiter;
  localparam int DEPTH = 4;
  localparam int STARVE_LIMIT = 3;

  logic clk = 1'b0;
  logic resetn;
  logic inst_req, data_req, data_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  data_size;
  logic [31:0] inst_addr, data_addr, data_wdata, bus_rdata;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, inst_rdata, data_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner queue, lock flag/owner, starvation count.
  bit mq[$];
  bit m_lock, m_lock_own;
  int m_starve;

  logic s_iaok, s_daok, s_idok, s_ddok, s_breq;
  logic [31:0] s_baddr;

  task automatic idle();
    resetn = 1'b1; inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    data_size = 2'd0; inst_addr = 32'd0; data_addr = 32'd0; data_wdata = 32'd0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
  endtask

  // Called 1 time unit after a posedge with inputs already driven.
  task automatic tick();
    int  g;
    bit  full, acc, pop, hold;
    #4;
    hold = m_lock && (m_lock_own ? data_req : inst_req);
    if (hold) g = m_lock_own ? 2 : 1;
    else if (inst_req && data_req && m_starve == STARVE_LIMIT) g = 1;
    else if (data_req) g = 2;
    else if (inst_req) g = 1;
    else g = 0;
    full = (mq.size() >= DEPTH);
    acc  = (g != 0) && !full && bus_addr_ok;
    pop  = bus_data_ok && (mq.size() > 0);

    chk("bus_req", bus_req, (g != 0) && !full);
    if (g == 1) begin
      chk("bus_addr_i", bus_addr, inst_addr);
      chk("bus_size_i", bus_size, 2);
      chk("bus_wr_i", bus_wr, 0);
      chk("bus_wdata_i", bus_wdata, 0);
    end else if (g == 2) begin
      chk("bus_addr_d", bus_addr, data_addr);
      chk("bus_size_d", bus_size, data_size);
      chk("bus_wr_d", bus_wr, data_wr);
      chk("bus_wdata_d", bus_wdata, data_wdata);
    end
    chk("inst_addr_ok", inst_addr_ok, acc && g == 1);
    chk("data_addr_ok", data_addr_ok, acc && g == 2);
    chk("inst_data_ok", inst_data_ok, pop ? (mq[0] == 1'b0) : 1'b0);
    chk("data_data_ok", data_data_ok, pop ? (mq[0] == 1'b1) : 1'b0);
    chk("inst_rdata", inst_rdata, bus_rdata);
    chk("data_rdata", data_rdata, bus_rdata);

    s_iaok = inst_addr_ok; s_daok = data_addr_ok; s_idok = inst_data_ok;
    s_ddok = data_data_ok; s_breq = bus_req; s_baddr = bus_addr;

    if (!resetn) begin
      mq.delete(); m_lock = 0; m_lock_own = 0; m_starve = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(g == 2);
      if (m_lock && !hold) m_lock = 0;
      if ((g != 0) && !full) begin
        m_lock = !bus_addr_ok;
        m_lock_own = (g == 2);
      end
      if (!inst_req || (acc && g == 1)) m_starve = 0;
      else if (acc && g == 2 && m_starve < STARVE_LIMIT) m_starve++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    m_lock = 0; m_lock_own = 0; m_starve = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state with idle inputs
    tick();
    chk("rst_breq", s_breq, 0);
    chk("rst_baddr", s_baddr, 0);

    // Single fetch and its response two cycles later
    inst_req = 1; inst_addr = 32'hBFC0_0000; bus_addr_ok = 1;
    tick();
    chk("t1_iaok", s_iaok, 1);
    chk("t1_addr", s_baddr, 32'hBFC0_0000);
    idle(); tick();
    bus_data_ok = 1; bus_rdata = 32'h3C08_0001;
    tick();
    chk("t1_idok", s_idok, 1);
    chk("t1_ddok", s_ddok, 0);
    idle();

    // Starvation guard ordering: D D D I D D D I
    inst_req = 1; inst_addr = 32'h0040_0000; data_req = 1; data_addr = 32'h1000_0000;
    data_size = 2'd2; bus_addr_ok = 1; bus_data_ok = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("starve_ord_d", s_daok, (i % 4) != 3);
      chk("starve_ord_i", s_iaok, (i % 4) == 3);
    end
    idle(); bus_data_ok = 1; tick();
    idle();

    // Data lock holds against a rising fetch; withdrawal hands over at once
    data_req = 1; data_addr = 32'h1000_0040; data_wr = 1; data_wdata = 32'hA5A5_5A5A;
    tick();
    inst_req = 1; inst_addr = 32'hBFC0_0010;
    tick();
    chk("lock_d_addr", s_baddr, 32'h1000_0040);
    data_req = 0;
    tick();
    chk("lock_rel_addr", s_baddr, 32'hBFC0_0010);
    chk("lock_rel_breq", s_breq, 1);
    bus_addr_ok = 1;
    tick();
    chk("lock_rel_iaok", s_iaok, 1);
    idle();
    // Fetch lock beats data priority
    inst_req = 1; inst_addr = 32'hBFC0_0020;
    tick();
    data_req = 1; data_addr = 32'h1000_0080;
    tick();
    chk("lock_i_addr", s_baddr, 32'hBFC0_0020);
    bus_addr_ok = 1; data_req = 0;
    tick();
    idle(); bus_data_ok = 1; tick(); tick(); tick();
    idle();

    // Fill to DEPTH, stall, then drain in order
    for (int i = 0; i < 4; i++) begin
      idle();
      inst_req = (i % 2 == 0); data_req = (i % 2 == 1);
      inst_addr = 32'h100 + i; data_addr = 32'h200 + i; bus_addr_ok = 1;
      tick();
    end
    idle(); inst_req = 1; bus_addr_ok = 1;
    tick();
    chk("full_breq", s_breq, 0);
    chk("full_iaok", s_iaok, 0);
    for (int i = 0; i < 4; i++) begin
      idle(); bus_data_ok = 1; bus_rdata = 32'hD000 + i;
      tick();
      chk("drain_idok", s_idok, i % 2 == 0);
      chk("drain_ddok", s_ddok, i % 2 == 1);
    end
    idle(); inst_req = 1; bus_addr_ok = 1;
    tick();
    chk("resume_iaok", s_iaok, 1);
    idle(); bus_data_ok = 1; tick();

    // Full with simultaneous pop: no grant that cycle, accepted the next
    for (int i = 0; i < 4; i++) begin
      idle(); data_req = 1; data_addr = 32'h300 + i; bus_addr_ok = 1;
      tick();
    end
    idle(); inst_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
    tick();
    chk("fullpop_breq", s_breq, 0);
    chk("fullpop_ddok", s_ddok, 1);
    bus_data_ok = 0;
    tick();
    chk("fullpop_next", s_iaok, 1);
    idle(); bus_data_ok = 1;
    repeat (4) tick();
    tick();
    chk("spur_idok", s_idok, 0);
    chk("spur_ddok", s_ddok, 0);

    // Reset with outstanding requests
    idle(); data_req = 1; bus_addr_ok = 1;
    repeat (3) tick();
    idle(); inst_req = 1; resetn = 0;
    tick();
    idle(); bus_data_ok = 1;
    tick();
    chk("rst_mid_idok", s_idok, 0);
    chk("rst_mid_ddok", s_ddok, 0);
    idle(); data_req = 1; data_addr = 32'h1000_1000; bus_addr_ok = 1;
    tick();
    chk("rst_after_daok", s_daok, 1);
    idle(); bus_data_ok = 1; bus_rdata = 32'h1234_5678;
    tick();
    chk("rst_after_ddok", s_ddok, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      resetn      = ($urandom_range(0, 299) != 0);
      inst_req    = ($urandom_range(0, 2) != 0);
      data_req    = ($urandom_range(0, 2) != 0);
      data_wr     = $urandom_range(0, 1);
      data_size   = 2'($urandom_range(0, 2));
      inst_addr   = $urandom;
      data_addr   = $urandom;
      data_wdata  = $urandom;
      bus_addr_ok = ($urandom_range(0, 4) < 3);
      bus_data_ok = ($urandom_range(0, 4) < 2);
      bus_rdata   = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
